gamefile_frame_reader: RTL



---
 rtl/gamefile_pkg.sv | 62 ++++++
 rtl/gamefile_header_decode.sv | 43 ++++
 rtl/gamefile_frame_reader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gamefile_pkg.sv
// Slot map, scan states and header bundle shared by the gamefile
// frame reader and its header decoder.
package gamefile_pkg;

    localparam int SLOT_BG         = 0;
    localparam int SLOT_P1_X       = 1;
    localparam int SLOT_P1_Y       = 2;
    localparam int SLOT_P1_IMAGE   = 3;
    localparam int SLOT_P1_FACE    = 4;
    localparam int SLOT_SHOW       = 5;
    localparam int SLOT_P2_X       = 6;
    localparam int SLOT_P2_Y       = 7;
    localparam int SLOT_P2_IMAGE   = 8;
    localparam int SLOT_P2_FACE    = 9;
    localparam int SLOT_BUL_STATUS = 10;

    // Header coordinates are carried wide and trimmed at the top level
    localparam int HDR_COORD_W  = 16;
    localparam int HDR_STATUS_W = 32;

    function automatic int bullet_x_slot(input int k);
        return 11 + 2 * k;
    endfunction

    function automatic int bullet_y_slot(input int k);
        return 12 + 2 * k;
    endfunction

    function automatic int hp_slot_base(input int n);
        return 11 + 2 * n;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } scan_state_e;

    typedef struct packed {
        logic [3:0]              current_bg;
        logic [HDR_COORD_W-1:0]  p1_x;
        logic [HDR_COORD_W-1:0]  p1_y;
        logic [3:0]              p1_image;
        logic                    p1_face_dir;
        logic                    show_p1;
        logic                    show_p2;
        logic [HDR_COORD_W-1:0]  p2_x;
        logic [HDR_COORD_W-1:0]  p2_y;
        logic [3:0]              p2_image;
        logic                    p2_face_dir;
        logic [HDR_STATUS_W-1:0] bullet_status;
        logic [4:0]              p1_hp;
        logic [4:0]              p2_hp;
        logic [HDR_COORD_W-1:0]  p1_hp_x;
        logic [HDR_COORD_W-1:0]  p1_hp_y;
        logic [HDR_COORD_W-1:0]  p2_hp_x;
        logic [HDR_COORD_W-1:0]  p2_hp_y;
        logic [HDR_COORD_W-1:0]  hp_interval;
    } header_t;

endpackage

// File: rtl/gamefile_header_decode.sv
// Combinational slicing of the shadowed gamefile into header fields;
// every field is the low bits of its slot.
module gamefile_header_decode
    import gamefile_pkg::*;
#(
    parameter int FILE_W      = 2048,
    parameter int WORD_W      = 32,
    parameter int NUM_BULLETS = 10
) (
    input  logic [FILE_W-1:0] i_shadow,
    output header_t           o_hdr
);

    localparam int B = hp_slot_base(NUM_BULLETS);

    always_comb begin
        o_hdr = '0;
        o_hdr.current_bg  = i_shadow[SLOT_BG*WORD_W +: 4];
        o_hdr.p1_x        = i_shadow[SLOT_P1_X*WORD_W +: HDR_COORD_W];
        o_hdr.p1_y        = i_shadow[SLOT_P1_Y*WORD_W +: HDR_COORD_W];
        o_hdr.p1_image    = i_shadow[SLOT_P1_IMAGE*WORD_W +: 4];
        o_hdr.p1_face_dir = i_shadow[SLOT_P1_FACE*WORD_W];
        o_hdr.show_p1     = i_shadow[SLOT_SHOW*WORD_W];
        o_hdr.show_p2     = i_shadow[SLOT_SHOW*WORD_W+1];
        o_hdr.p2_x        = i_shadow[SLOT_P2_X*WORD_W +: HDR_COORD_W];
        o_hdr.p2_y        = i_shadow[SLOT_P2_Y*WORD_W +: HDR_COORD_W];
        o_hdr.p2_image    = i_shadow[SLOT_P2_IMAGE*WORD_W +: 4];
        o_hdr.p2_face_dir = i_shadow[SLOT_P2_FACE*WORD_W];
        o_hdr.bullet_status[NUM_BULLETS-1:0] =
            i_shadow[SLOT_BUL_STATUS*WORD_W +: NUM_BULLETS];
        o_hdr.p1_hp       = i_shadow[B*WORD_W +: 5];
        o_hdr.p2_hp       = i_shadow[(B+1)*WORD_W +: 5];
        o_hdr.p1_hp_x     = i_shadow[(B+2)*WORD_W +: HDR_COORD_W];
        o_hdr.p1_hp_y     = i_shadow[(B+3)*WORD_W +: HDR_COORD_W];
        o_hdr.p2_hp_x     = i_shadow[(B+4)*WORD_W +: HDR_COORD_W];
        o_hdr.p2_hp_y     = i_shadow[(B+5)*WORD_W +: HDR_COORD_W];
        o_hdr.hp_interval = i_shadow[(B+6)*WORD_W +: HDR_COORD_W];
    end

    logic w_unused;
    assign w_unused = ^i_shadow;

endmodule

// File: rtl/gamefile_frame_reader.sv
// Frame-synchronous gamefile reader: shadows the gamefile on each tick
// and streams active bullet slots to the sprite renderer.
module gamefile_frame_reader
    import gamefile_pkg::*;
#(
    parameter int  FILE_W      = 2048,
    parameter int  WORD_W      = 32,
    parameter int  COORD_W     = 10,
    parameter int  NUM_BULLETS = 10,
    localparam int IDX_W       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [FILE_W-1:0]      gamefile,
    input  logic                   frame_tick,
    output logic [3:0]             current_bg,
    output logic [COORD_W-1:0]     p1_x,
    output logic [COORD_W-1:0]     p1_y,
    output logic [3:0]             p1_image,
    output logic                   p1_face_dir,
    output logic                   show_p1,
    output logic                   show_p2,
    output logic [COORD_W-1:0]     p2_x,
    output logic [COORD_W-1:0]     p2_y,
    output logic [3:0]             p2_image,
    output logic                   p2_face_dir,
    output logic [NUM_BULLETS-1:0] bullet_status,
    output logic [4:0]             p1_hp,
    output logic [4:0]             p2_hp,
    output logic [COORD_W-1:0]     p1_hp_x,
    output logic [COORD_W-1:0]     p1_hp_y,
    output logic [COORD_W-1:0]     p2_hp_x,
    output logic [COORD_W-1:0]     p2_hp_y,
    output logic [COORD_W-1:0]     hp_interval,
    output logic [7:0]             frame_id,
    output logic                   bul_valid,
    input  logic                   bul_ready,
    output logic [IDX_W-1:0]       bul_idx,
    output logic [COORD_W-1:0]     bul_x,
    output logic [COORD_W-1:0]     bul_y,
    output logic                   scan_done,
    output logic [7:0]             overrun_cnt
);

    localparam int FW = $clog2(FILE_W);

    logic [FILE_W-1:0]  r_shadow;
    scan_state_e        r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_frame_id;
    logic [7:0]         r_overrun;
    logic               r_bul_valid;
    logic [IDX_W-1:0]   r_bul_idx;
    logic [COORD_W-1:0] r_bul_x;
    logic [COORD_W-1:0] r_bul_y;
    logic               r_scan_done;

    header_t                w_hdr;
    logic [NUM_BULLETS-1:0] w_status;
    logic [FW-1:0]          w_xbase;
    logic [FW-1:0]          w_ybase;
    logic [COORD_W-1:0]     w_slot_x;
    logic [COORD_W-1:0]     w_slot_y;
    logic                   w_last;
    logic                   w_busy;

    gamefile_header_decode #(
        .FILE_W      (FILE_W),
        .WORD_W      (WORD_W),
        .NUM_BULLETS (NUM_BULLETS)
    ) u_decode (
        .i_shadow (r_shadow),
        .o_hdr    (w_hdr)
    );

    assign w_status = w_hdr.bullet_status[NUM_BULLETS-1:0];
    assign w_xbase  = FW'(bullet_x_slot(int'(r_idx)) * WORD_W);
    assign w_ybase  = FW'(bullet_y_slot(int'(r_idx)) * WORD_W);
    assign w_slot_x = r_shadow[w_xbase +: COORD_W];
    assign w_slot_y = r_shadow[w_ybase +: COORD_W];
    assign w_last   = (r_idx == IDX_W'(NUM_BULLETS - 1));
    assign w_busy   = (r_state == ST_SCAN) || (r_state == ST_EMIT);

    // A tick restarts the scan from any state; an unfinished scan is an overrun
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shadow    <= '0;
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_frame_id  <= '0;
            r_overrun   <= '0;
            r_bul_valid <= 1'b0;
            r_bul_idx   <= '0;
            r_bul_x     <= '0;
            r_bul_y     <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (frame_tick) begin
                r_shadow    <= gamefile;
                r_frame_id  <= r_frame_id + 8'd1;
                r_idx       <= '0;
                r_state     <= ST_SCAN;
                r_bul_valid <= 1'b0;
                if (w_busy && (r_overrun != 8'hFF)) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_SCAN: begin
                        if (w_status[r_idx]) begin
                            r_bul_idx   <= r_idx;
                            r_bul_x     <= w_slot_x;
                            r_bul_y     <= w_slot_y;
                            r_bul_valid <= 1'b1;
                            r_state     <= ST_EMIT;
                        end else if (w_last) begin
                            r_state     <= ST_DONE;
                            r_scan_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                    ST_EMIT: begin
                        if (bul_ready) begin
                            r_bul_valid <= 1'b0;
                            if (w_last) begin
                                r_state     <= ST_DONE;
                                r_scan_done <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + IDX_W'(1);
                                r_state <= ST_SCAN;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign current_bg    = w_hdr.current_bg;
    assign p1_x          = w_hdr.p1_x[COORD_W-1:0];
    assign p1_y          = w_hdr.p1_y[COORD_W-1:0];
    assign p1_image      = w_hdr.p1_image;
    assign p1_face_dir   = w_hdr.p1_face_dir;
    assign show_p1       = w_hdr.show_p1;
    assign show_p2       = w_hdr.show_p2;
    assign p2_x          = w_hdr.p2_x[COORD_W-1:0];
    assign p2_y          = w_hdr.p2_y[COORD_W-1:0];
    assign p2_image      = w_hdr.p2_image;
    assign p2_face_dir   = w_hdr.p2_face_dir;
    assign bullet_status = w_status;
    assign p1_hp         = w_hdr.p1_hp;
    assign p2_hp         = w_hdr.p2_hp;
    assign p1_hp_x       = w_hdr.p1_hp_x[COORD_W-1:0];
    assign p1_hp_y       = w_hdr.p1_hp_y[COORD_W-1:0];
    assign p2_hp_x       = w_hdr.p2_hp_x[COORD_W-1:0];
    assign p2_hp_y       = w_hdr.p2_hp_y[COORD_W-1:0];
    assign hp_interval   = w_hdr.hp_interval[COORD_W-1:0];

    assign frame_id    = r_frame_id;
    assign overrun_cnt = r_overrun;
    assign bul_valid   = r_bul_valid;
    assign bul_idx     = r_bul_idx;
    assign bul_x       = r_bul_x;
    assign bul_y       = r_bul_y;
    assign scan_done   = r_scan_done;

    logic w_unused_hdr;
    assign w_unused_hdr = ^w_hdr;

endmodule
